// File: rtl/joypad_port.sv
// rtl/joypad_port.sv - two-pad serial joypad scanner with $4016/$4017 CPU read port
//
// Purpose:
//   Periodically scans two serial joypads that share one latch line and one
//   shift clock. Each scan commits an 8-bit snapshot per pad. The CPU sees
//   the snapshots through the usual strobe/shift register pair at $4016/$4017.
//
// Ports:
//   clk                    system clock; all logic runs in this domain
//   rst                    asynchronous active-low reset
//   cpu_addr/din/we/re     CPU bus: address, write data, one-cycle strobes
//   dout                   combinational read data ($00 when not addressed)
//   hit                    combinational decode of $4016/$4017
//   pad_latch, pad_clk     registered latch and shift clock to both pads
//   pad_data1, pad_data2   serial pad data, active-low
//   buttons1, buttons2     committed snapshots, active-high (A,B,Sel,Start,U,D,L,R)
//   poll_done              one-cycle pulse on the cycle the snapshots update
module joypad_port #(
  parameter int LATCH_CYC = 258,
  parameter int HALF_CYC  = 129,
  parameter int POLL_CYC  = 357955
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_data1,
  input  logic        pad_data2,
  output logic [7:0]  buttons1,
  output logic [7:0]  buttons2,
  output logic        poll_done
);

  localparam int CW = $clog2(POLL_CYC + 1);

  localparam logic [2:0] S_LATCH  = 3'd0;
  localparam logic [2:0] S_CLK_HI = 3'd1;
  localparam logic [2:0] S_CLK_LO = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);

  logic [2:0]    state;
  logic [CW-1:0] phase_cnt;
  logic [CW-1:0] poll_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    work1;
  logic [7:0]    work2;
  logic [7:0]    sh1;
  logic [7:0]    sh2;
  logic          strobe;
  logic          unused_din;

  assign unused_din = ^cpu_din[7:1];

  // state/phase_cnt/poll_cnt name the cycle that the next edge presents, so
  // the registered pad outputs are derived directly from them. This puts the
  // first pad_latch=1 on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LATCH;
      phase_cnt <= '0;
      poll_cnt  <= '0;
      bit_idx   <= 3'd0;
      work1     <= 8'h00;
      work2     <= 8'h00;
      buttons1  <= 8'h00;
      buttons2  <= 8'h00;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      poll_done <= 1'b0;
    end else begin
      pad_latch <= (state == S_LATCH);
      pad_clk   <= (state == S_CLK_HI);
      poll_done <= (state == S_COMMIT);
      poll_cnt  <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;

      case (state)
        S_LATCH: begin
          if (phase_cnt == LATCH_LAST) begin
            // Pads present bit 0 (A) while latched.
            work1[0]  <= ~pad_data1;
            work2[0]  <= ~pad_data2;
            state     <= S_CLK_HI;
            phase_cnt <= '0;
            bit_idx   <= 3'd1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_CLK_HI: begin
          if (phase_cnt == HALF_LAST) begin
            state     <= S_CLK_LO;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_CLK_LO: begin
          if (phase_cnt == HALF_LAST) begin
            // Data settled since the rising pad_clk; sample at the end of low.
            work1[bit_idx] <= ~pad_data1;
            work2[bit_idx] <= ~pad_data2;
            phase_cnt      <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_COMMIT;
            end else begin
              state   <= S_CLK_HI;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          buttons1 <= work1;
          buttons2 <= work2;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Leave when the last cycle of the poll period is presented, so the
          // next latch lands exactly POLL_CYC cycles after the previous one.
          if (poll_cnt == POLL_LAST) begin
            state     <= S_LATCH;
            phase_cnt <= '0;
          end
        end
        default: begin
          state     <= S_LATCH;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  assign hit = (cpu_addr == 16'h4016) || (cpu_addr == 16'h4017);

  always_comb begin
    dout = 8'h00;
    if (hit) begin
      dout = {7'b0100000, (cpu_addr[0] ? sh2[0] : sh1[0])};
    end
  end

  // Reload uses the pre-edge strobe and buttons values; a write never lets
  // a simultaneous read shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe <= 1'b0;
      sh1    <= 8'h00;
      sh2    <= 8'h00;
    end else begin
      if (cpu_we && (cpu_addr == 16'h4016)) begin
        strobe <= cpu_din[0];
      end
      if (strobe) begin
        sh1 <= buttons1;
        sh2 <= buttons2;
      end else if (cpu_re && hit && !cpu_we) begin
        if (cpu_addr[0]) begin
          sh2 <= {1'b1, sh2[7:1]};
        end else begin
          sh1 <= {1'b1, sh1[7:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_joypad_port.sv
// tb/tb_joypad_port.sv - self-checking bench for joypad_port
module tb_joypad_port;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 2;
  localparam int POLL_CYC  = 64;
  localparam int SCAN_END  = LATCH_CYC + 14 * HALF_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  dout;
  logic        hit;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data1;
  logic        pad_data2;
  logic [7:0]  buttons1;
  logic [7:0]  buttons2;
  logic        poll_done;

  int checks = 0;
  int errors = 0;

  joypad_port #(
    .LATCH_CYC(LATCH_CYC),
    .HALF_CYC (HALF_CYC),
    .POLL_CYC (POLL_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .dout     (dout),
    .hit      (hit),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .pad_data1(pad_data1),
    .pad_data2(pad_data2),
    .buttons1 (buttons1),
    .buttons2 (buttons2),
    .poll_done(poll_done)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load on latch, one bit advanced per pad_clk rise.
  logic [7:0] pad1_btn = 8'h00;
  logic [7:0] pad2_btn = 8'h00;
  logic [7:0] snap1 = 8'h00;
  logic [7:0] snap2 = 8'h00;
  int         idx = 8;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      snap1 = pad1_btn;
      snap2 = pad2_btn;
      idx   = 0;
    end else begin
      idx = idx + 1;
    end
  end

  assign pad_data1 = (idx < 8) ? ~snap1[idx[2:0]] : 1'b0;
  assign pad_data2 = (idx < 8) ? ~snap2[idx[2:0]] : 1'b0;

  // Reference model: committed buttons, strobe, and per-port snapshot plus
  // number of reads consumed since that snapshot was taken.
  logic [7:0] exp_b1 = 8'h00;
  logic [7:0] exp_b2 = 8'h00;
  logic       m_strobe = 1'b0;
  logic [7:0] m_snap1 = 8'h00;
  logic [7:0] m_snap2 = 8'h00;
  int         m_n1 = 0;
  int         m_n2 = 0;

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    logic [7:0] s;
    int         n;
    if (a != 16'h4016 && a != 16'h4017) return 8'h00;
    if (m_strobe) return 8'h40 | {7'b0, (a[0] ? exp_b2[0] : exp_b1[0])};
    s = a[0] ? m_snap2 : m_snap1;
    n = a[0] ? m_n2 : m_n1;
    return 8'h40 | {7'b0, ((n < 8) ? s[n[2:0]] : 1'b1)};
  endfunction

  task automatic model_reset();
    exp_b1 = 8'h00; exp_b2 = 8'h00; m_strobe = 1'b0;
    m_snap1 = 8'h00; m_snap2 = 8'h00; m_n1 = 0; m_n2 = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h4016) begin
      if (m_strobe && !d[0]) begin
        m_snap1 = exp_b1; m_snap2 = exp_b2; m_n1 = 0; m_n2 = 0;
      end
      m_strobe = d[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic cpu_read(input logic [15:0] a, input string name);
    logic [7:0] e;
    cpu_addr = a; cpu_re = 1'b1;
    #1;
    e = exp_read(a);
    checks++;
    if (dout !== e) begin
      errors++;
      $display("FAIL %s addr=%h: dout=%h expected=%h", name, a, dout, e);
    end
    tick();
    cpu_re = 1'b0;
    if (!m_strobe) begin
      if (a == 16'h4016) m_n1++;
      if (a == 16'h4017) m_n2++;
    end
  endtask

  // Write and read in the same cycle: the read sees current data, no shift.
  task automatic cpu_rw(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] e;
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1; cpu_re = 1'b1;
    #1;
    e = exp_read(a);
    checks++;
    if (dout !== e) begin
      errors++;
      $display("FAIL rw_read addr=%h: dout=%h expected=%h", a, dout, e);
    end
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    model_write(a, d);
  endtask

  task automatic wait_poll();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!poll_done && n < 200);
    checks++;
    if (!poll_done) begin
      errors++;
      $display("FAIL wait_poll: poll_done=%b after %0d cycles expected=1", poll_done, n);
    end
  endtask

  task automatic check_buttons(input string name);
    checks++;
    if (buttons1 !== exp_b1 || buttons2 !== exp_b2) begin
      errors++;
      $display("FAIL %s: buttons1=%h buttons2=%h expected=%h/%h",
               name, buttons1, buttons2, exp_b1, exp_b2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    checks++;
    if ({pad_latch, pad_clk, poll_done} !== 3'b000 || buttons1 !== 8'h00 || buttons2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: latch=%b clk=%b done=%b b1=%h b2=%h expected all 0",
               pad_latch, pad_clk, poll_done, buttons1, buttons2);
    end
    cpu_addr = 16'h4016; #1;
    checks++;
    if (hit !== 1'b1 || dout !== 8'h40) begin
      errors++;
      $display("FAIL reset_read_4016: hit=%b dout=%h expected 1/40", hit, dout);
    end
    cpu_addr = 16'h4017; #1;
    checks++;
    if (hit !== 1'b1 || dout !== 8'h40) begin
      errors++;
      $display("FAIL reset_read_4017: hit=%b dout=%h expected 1/40", hit, dout);
    end
    cpu_addr = 16'h4015; #1;
    checks++;
    if (hit !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL nohit_4015: hit=%b dout=%h expected 0/00", hit, dout);
    end
  endtask

  task automatic test_scan_timing();
    int  m;
    logic e_latch, e_clk, e_done;
    pad1_btn = 8'h09;
    pad2_btn = 8'h80;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      tick();
      m = k % POLL_CYC;
      e_latch = (m < LATCH_CYC);
      e_clk   = (m >= LATCH_CYC) && (m < SCAN_END) && ((((m - LATCH_CYC) / HALF_CYC) % 2) == 0);
      e_done  = (m == SCAN_END);
      checks++;
      if (pad_latch !== e_latch || pad_clk !== e_clk || poll_done !== e_done) begin
        errors++;
        $display("FAIL scan_cycle_%0d: latch/clk/done=%b%b%b expected=%b%b%b",
                 k, pad_latch, pad_clk, poll_done, e_latch, e_clk, e_done);
      end
      if (k < SCAN_END) begin
        checks++;
        if (buttons1 !== 8'h00) begin
          errors++;
          $display("FAIL early_buttons cycle %0d: buttons1=%h expected=00", k, buttons1);
        end
      end
      if (k == SCAN_END) begin
        exp_b1 = 8'h09;
        exp_b2 = 8'h80;
        check_buttons("scan_commit");
      end
    end
  endtask

  task automatic test_read_sequence();
    wait_poll();
    tick();
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) cpu_read(16'h4016, "read_seq");
  endtask

  task automatic test_strobe_held();
    wait_poll();
    pad1_btn = 8'($urandom) | 8'h01;
    wait_poll();
    exp_b1 = pad1_btn;
    tick();
    check_buttons("strobe_a_pressed");
    cpu_write(16'h4016, 8'h01);
    tick();
    for (int i = 0; i < 3; i++) cpu_read(16'h4016, "strobe_held_pressed");
    pad1_btn = 8'($urandom) & 8'hFE;
    wait_poll();
    exp_b1 = pad1_btn;
    tick();
    cpu_read(16'h4016, "strobe_held_released");
    cpu_write(16'h4016, 8'h00);
  endtask

  task automatic test_pad_independence();
    wait_poll();
    pad1_btn = 8'($urandom);
    pad2_btn = 8'h80;
    wait_poll();
    exp_b1 = pad1_btn;
    exp_b2 = pad2_btn;
    tick();
    check_buttons("pad_indep");
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cpu_read(16'h4017, "indep_4017");
      cpu_read(16'h4016, "indep_4016");
    end
  endtask

  task automatic test_commit_mid_read();
    logic [7:0] old;
    wait_poll();
    old = 8'($urandom);
    pad1_btn = old;
    wait_poll();
    exp_b1 = old;
    tick();
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 3; i++) cpu_read(16'h4016, "mid_read_pre");
    pad1_btn = old ^ (8'($urandom) | 8'h01);
    wait_poll();
    exp_b1 = pad1_btn;
    check_buttons("mid_read_commit");
    tick();
    for (int i = 3; i < 9; i++) cpu_read(16'h4016, "mid_read_post");
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 6; it++) begin
      wait_poll();
      pad1_btn = 8'($urandom);
      pad2_btn = 8'($urandom);
      wait_poll();
      exp_b1 = pad1_btn;
      exp_b2 = pad2_btn;
      tick();
      check_buttons("rand_commit");
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      for (int j = 0; j < 16; j++) begin
        op = $urandom_range(0, 3);
        case (op)
          0: cpu_read(16'h4016, "rand_4016");
          1: cpu_read(16'h4017, "rand_4017");
          2: begin
            cpu_read(16'h4018 + 16'($urandom_range(0, 7)), "rand_nohit");
            checks++;
            if (hit !== 1'b0) begin
              errors++;
              $display("FAIL rand_nohit_hit: hit=%b expected=0", hit);
            end
          end
          default: cpu_rw(16'h4016 + 16'($urandom_range(0, 1)), 8'($urandom) & 8'hFE);
        endcase
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    wait_poll();
    while (!pad_clk && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!pad_clk) begin
      errors++;
      $display("FAIL find_clk_hi: pad_clk=%b expected=1", pad_clk);
    end
    #2;
    rst = 1'b0;
    model_reset();
    cpu_addr = 16'h4016;
    #1;
    checks++;
    if (pad_clk !== 1'b0 || pad_latch !== 1'b0 || buttons1 !== 8'h00 || buttons2 !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: clk=%b latch=%b b1=%h b2=%h expected 0/0/00/00",
               pad_clk, pad_latch, buttons1, buttons2);
    end
    checks++;
    if (dout !== 8'h40) begin
      errors++;
      $display("FAIL async_reset_read: dout=%h expected=40", dout);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (poll_done !== 1'b0 || pad_latch !== 1'b0) begin
        errors++;
        $display("FAIL held_reset: done=%b latch=%b expected 0/0", poll_done, pad_latch);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pad_latch !== 1'b1) begin
      errors++;
      $display("FAIL first_latch_after_reset: pad_latch=%b expected=1", pad_latch);
    end
    wait_poll();
    exp_b1 = pad1_btn;
    exp_b2 = pad2_btn;
    check_buttons("rescan_after_reset");
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_read_sequence();
    test_strobe_held();
    test_pad_independence();
    test_commit_mid_read();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
